addsub_seq: RTL
===============

// Module: addsub_seq
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: processes CHUNK bits per clock over WIDTH/CHUNK cycles
//  with a registered carry chain, so wide operands do not form one long combinational ripple path.
//  Runtime add/sub mode, valid/ready handshakes on input and output, and N/Z/C/V flags.
//  Sits beside the ALU as the shared arithmetic unit for wide or non-critical-path add/sub.
// PARAMETERS
//  WIDTH  64  operand/result width in bits; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  CHUNK  16  bits processed per cycle; NCH = WIDTH/CHUNK; CHUNK == WIDTH gives a single-cycle CALC
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request
//  sub        in   1      0: op1+op2, 1: op1-op2; sampled on accept
//  op1        in   WIDTH  operand 1; sampled on accept
//  op2        in   WIDTH  operand 2; sampled on accept
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes the result
//  result     out  WIDTH  sum or difference, modulo 2^WIDTH
//  flag_n     out  1      result[WIDTH-1]
//  flag_z     out  1      result == 0
//  flag_c     out  1      add: carry out; sub: borrow (op1 < op2 unsigned)
//  flag_v     out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; in_ready=1; out_valid=0; result and all flags = 0.
//    Reset mid-CALC or in DONE aborts: the pending result is dropped and no out_valid is produced.
//  - FSM states IDLE -> CALC -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid&in_ready: latch op1, op2 and sub into internal registers;
//      stored b = sub ? ~op2 : op2; carry register = sub; chunk index k = 0; go to CALC.
//    CALC: in_ready=0. Each edge: {c, r[k*CHUNK +: CHUNK]} = a_chunk + b_chunk + carry;
//      carry <= c; k <= k+1. After the edge that processes k = NCH-1, go to DONE and compute flags.
//    DONE: out_valid=1; result and flags held stable. On out_ready=1: go to IDLE, out_valid -> 0.
//  - Latency: request accepted at edge t -> out_valid is 1 in the cycle after edge t+NCH.
//    Default parameters give NCH = 4.
//  - Throughput: one operation per NCH+2 cycles at best. in_ready is 1 only in IDLE; there is no
//    accept in the DONE->IDLE cycle.
//  - Flags, with cout = final carry:
//      flag_c = sub ? ~cout : cout
//      flag_v = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]), where b is the stored (inverted if sub) op2
//      flag_n = result[W-1]
//      flag_z = ~|result
//  - result and flags are registered. They change only on entry to DONE or on reset; their values
//    outside DONE are don't-care to consumers but must not glitch within DONE.
//  - in_valid is ignored outside IDLE. Changes to op1/op2/sub after accept have no effect.
//  - out_ready while out_valid=0 is ignored.
//  - Wrap: results are modulo 2^WIDTH; no saturation.
// TESTING  (WIDTH=64, CHUNK=16 unless noted; hex values)
//  1. Add with carry ripple across chunk boundaries:
//     op1=0000_0000_0000_FFFF, op2=1, sub=0 -> result=0000_0000_0001_0000, C=0, V=0, Z=0, N=0;
//     out_valid exactly 4 edges after accept.
//  2. Sub with borrow: op1=0, op2=1, sub=1 -> result=FFFF_FFFF_FFFF_FFFF, C=1, N=1, V=0, Z=0.
//  3. Signed overflow:
//     op1=7FFF_FFFF_FFFF_FFFF + op2=1 add -> result=8000_0000_0000_0000, V=1, N=1, C=0;
//     op1=8000_0000_0000_0000 - op2=1 -> result=7FFF_FFFF_FFFF_FFFF, V=1, C=0.
//  4. Zero/carry: op1=FFFF_FFFF_FFFF_FFFF + op2=1 -> result=0, Z=1, C=1, V=0;
//     op1=op2=1234_5678_9ABC_DEF0 sub -> result=0, Z=1, C=0.
//  5. Handshake/backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0,
//     a second in_valid is not accepted; release out_ready -> next request accepted one cycle later.
//  6. Reset mid-CALC (assert rst after chunk 2) -> out_valid never rises, outputs 0, in_ready=1.
//     Repeat tests 1-4 with CHUNK=64 (NCH=1) and CHUNK=8 (NCH=8), plus 2000 random ops
//     checked against a behavioural model.

Source files
------------

// File: rtl/addsub_seq_if.sv
// Request/response bundle for the chunked adder/subtractor: operand handshake in, result/flags out.
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, sub, op1, op2, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, sub, op1, op2, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry, N/Z/C/V flags,
// valid/ready on both sides. Operands shift right each step; the result fills from the top.
module addsub_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic        clk,
    input  logic        rst,
    addsub_seq_if.slave bus
);
    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW  = CHUNK + 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [CHUNK:0]   sum_c;
    logic [WIDTH-1:0] r_next_c;

    // One chunk of the ripple, and the partial result with the new chunk inserted at the top.
    always_comb begin
        sum_c    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + SW'(carry_q);
        r_next_c = (r_q >> CHUNK) | (WIDTH'(sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        result_d = result_q;
        k_d      = k_q;
        carry_d  = carry_q;
        sub_d    = sub_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.op1;
                    b_d     = bus.sub ? ~bus.op2 : bus.op2;
                    carry_d = bus.sub;
                    sub_d   = bus.sub;
                    a_msb_d = bus.op1[WIDTH-1];
                    b_msb_d = bus.sub ? ~bus.op2[WIDTH-1] : bus.op2[WIDTH-1];
                    r_d     = '0;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = sum_c[CHUNK];
                r_d     = r_next_c;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(NCH - 1)) begin
                    // Final chunk: publish result and flags as DONE is entered.
                    result_d = r_next_c;
                    n_d      = r_next_c[WIDTH-1];
                    z_d      = ~|r_next_c;
                    c_d      = sub_q ? ~sum_c[CHUNK] : sum_c[CHUNK];
                    v_d      = (a_msb_q == b_msb_q) && (r_next_c[WIDTH-1] != a_msb_q);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            result_q    <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            result_q    <= result_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
endmodule
